// File: rtl/anton_neopixel_pkg.sv
// rtl/anton_neopixel_pkg.sv - NeoPixel line encoding shared by the transmitter and receiver.
package anton_neopixel_pkg;

    typedef enum logic [1:0] {
        WAIT_RESET = 2'd0,
        LOW        = 2'd1,
        HIGH       = 2'd2
    } neo_state_t;

    localparam int TICKS_PER_BIT       = 12;
    localparam int T0H_TICKS           = 3;
    localparam int T1H_TICKS           = 8;
    localparam int BITS_PER_PIXEL      = 24;
    localparam int RESET_TICKS_DEFAULT = 500;

endpackage

// File: rtl/anton_neopixel_rx_sync.sv
// rtl/anton_neopixel_rx_sync.sv - 2-flop synchroniser with registered rise/fall detect for NEO_DIN.
module anton_neopixel_rx_sync (
    input  logic CLK_10MHZ,
    input  logic RESET_N,
    input  logic NEO_DIN,
    output logic din_sync,
    output logic rise,
    output logic fall
);

    logic din_meta;
    logic din_prev;

    always_ff @(posedge CLK_10MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            din_meta <= 1'b0;
            din_sync <= 1'b0;
            din_prev <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            din_meta <= NEO_DIN;
            din_sync <= din_meta;
            din_prev <= din_sync;
            rise     <= din_sync & ~din_prev;
            fall     <= ~din_sync & din_prev;
        end
    end

endmodule

// File: rtl/anton_neopixel_rx.sv
// rtl/anton_neopixel_rx.sv - NeoPixel stream decoder; 24-bit pixels, frame reset and error strobes.
// Optional daisy-chain pass-through on NEO_DOUT when ANTON_NEOPIXEL_RX_PASSTHROUGH_EN is defined.
module anton_neopixel_rx
    import anton_neopixel_pkg::*;
#(
    parameter int PIXELS_MAX     = 3,
    parameter int PIXELS_BITS    = 2,
    parameter int BIT_THRESHOLD  = 6,
    parameter int MAX_HIGH_TICKS = 11,
    parameter int RESET_TICKS    = RESET_TICKS_DEFAULT
) (
    input  logic                   CLK_10MHZ,
    input  logic                   RESET_N,
    input  logic                   NEO_DIN,
    output logic [23:0]            PIXEL_DATA,
    output logic [PIXELS_BITS-1:0] PIXEL_INDEX,
    output logic                   PIXEL_VALID,
    output logic                   FRAME_END,
    output logic                   ERROR,
    output logic                   NEO_DOUT
);

    localparam int LOW_W = $clog2(RESET_TICKS + 1);
    localparam int PIX_W = $clog2(PIXELS_MAX + 1);
    localparam logic [LOW_W-1:0] LOW_SAT  = LOW_W'(RESET_TICKS);
    localparam logic [LOW_W-1:0] LOW_PRE  = LOW_W'(RESET_TICKS - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXELS_MAX);
    localparam logic [3:0]       HI_ONE   = 4'(BIT_THRESHOLD);
    localparam logic [3:0]       HI_MAX   = 4'(MAX_HIGH_TICKS);
    localparam logic [4:0]       BIT_LAST = 5'(BITS_PER_PIXEL - 1);

    logic din_sync, rise, fall;

    neo_state_t                state, state_nxt;
    logic [LOW_W-1:0]          low_cnt, low_cnt_nxt;
    logic [3:0]                high_cnt, high_cnt_nxt;
    logic [4:0]                bit_idx, bit_idx_nxt;
    logic [PIX_W-1:0]          pix_idx, pix_idx_nxt;
    logic [BITS_PER_PIXEL-2:0] shift, shift_nxt;
    logic                      got_bit, got_bit_nxt;
    logic [23:0]               data_nxt;
    logic [PIXELS_BITS-1:0]    index_nxt;
    logic                      valid_nxt, frame_end_nxt, error_nxt;
    logic                      bit_val, reset_hit;

    anton_neopixel_rx_sync u_sync (
        .CLK_10MHZ (CLK_10MHZ),
        .RESET_N   (RESET_N),
        .NEO_DIN   (NEO_DIN),
        .din_sync  (din_sync),
        .rise      (rise),
        .fall      (fall)
    );

    always_ff @(posedge CLK_10MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= WAIT_RESET;
            low_cnt     <= '0;
            high_cnt    <= '0;
            bit_idx     <= '0;
            pix_idx     <= '0;
            shift       <= '0;
            got_bit     <= 1'b0;
            PIXEL_DATA  <= '0;
            PIXEL_INDEX <= '0;
            PIXEL_VALID <= 1'b0;
            FRAME_END   <= 1'b0;
            ERROR       <= 1'b0;
        end else begin
            state       <= state_nxt;
            low_cnt     <= low_cnt_nxt;
            high_cnt    <= high_cnt_nxt;
            bit_idx     <= bit_idx_nxt;
            pix_idx     <= pix_idx_nxt;
            shift       <= shift_nxt;
            got_bit     <= got_bit_nxt;
            PIXEL_DATA  <= data_nxt;
            PIXEL_INDEX <= index_nxt;
            PIXEL_VALID <= valid_nxt;
            FRAME_END   <= frame_end_nxt;
            ERROR       <= error_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        low_cnt_nxt   = low_cnt;
        high_cnt_nxt  = high_cnt;
        bit_idx_nxt   = bit_idx;
        pix_idx_nxt   = pix_idx;
        shift_nxt     = shift;
        got_bit_nxt   = got_bit;
        data_nxt      = PIXEL_DATA;
        index_nxt     = PIXEL_INDEX;
        valid_nxt     = 1'b0;
        frame_end_nxt = 1'b0;
        error_nxt     = 1'b0;
        bit_val       = (high_cnt >= HI_ONE);
        // low_cnt saturates at RESET_TICKS, so the reset event fires once per low period
        reset_hit     = (low_cnt == LOW_PRE);

        unique case (state)
            WAIT_RESET: begin
                if (din_sync) begin
                    low_cnt_nxt = '0;
                end else if (low_cnt != LOW_SAT) begin
                    low_cnt_nxt = low_cnt + LOW_W'(1);
                    if (reset_hit) begin
                        state_nxt   = LOW;
                        bit_idx_nxt = '0;
                        pix_idx_nxt = '0;
                        got_bit_nxt = 1'b0;
                    end
                end
            end
            LOW: begin
                if (rise) begin
                    state_nxt    = HIGH;
                    high_cnt_nxt = 4'd1;
                    low_cnt_nxt  = '0;
                end else if (low_cnt != LOW_SAT) begin
                    low_cnt_nxt = low_cnt + LOW_W'(1);
                    if (reset_hit) begin
                        error_nxt     = (bit_idx != 5'd0);
                        frame_end_nxt = got_bit;
                        bit_idx_nxt   = '0;
                        pix_idx_nxt   = '0;
                        got_bit_nxt   = 1'b0;
                    end
                end
            end
            HIGH: begin
                if (fall) begin
                    state_nxt   = LOW;
                    low_cnt_nxt = LOW_W'(1);
                    got_bit_nxt = 1'b1;
                    if (bit_idx == BIT_LAST) begin
                        bit_idx_nxt = '0;
                        if (pix_idx < PIX_LAST) begin
                            data_nxt    = {bit_val, shift};
                            index_nxt   = PIXELS_BITS'(pix_idx);
                            valid_nxt   = 1'b1;
                            pix_idx_nxt = pix_idx + PIX_W'(1);
                        end
                    end else begin
                        shift_nxt[bit_idx] = bit_val;
                        bit_idx_nxt        = bit_idx + 5'd1;
                    end
                end else begin
                    if (high_cnt != 4'd15) high_cnt_nxt = high_cnt + 4'd1;
                    // next tick would exceed the longest legal pulse
                    if (high_cnt >= HI_MAX) begin
                        error_nxt   = 1'b1;
                        state_nxt   = WAIT_RESET;
                        low_cnt_nxt = '0;
                    end
                end
            end
            default: state_nxt = WAIT_RESET;
        endcase
    end

`ifdef ANTON_NEOPIXEL_RX_PASSTHROUGH_EN
    assign NEO_DOUT = din_sync && (pix_idx == PIX_LAST) && (state == LOW || state == HIGH);
`else
    assign NEO_DOUT = 1'b0;
`endif

endmodule

// File: tb/tb_anton_neopixel_rx.sv
// tb/tb_anton_neopixel_rx.sv - directed and randomized bench for anton_neopixel_rx.
module tb_anton_neopixel_rx;

    localparam int PIXELS_MAX  = 3;
    localparam int RESET_TICKS = 500;
    localparam int EDGE_LAT    = 3;
    localparam int DETECT_LAT  = EDGE_LAT + 1;

    logic        CLK_10MHZ = 1'b0;
    logic        RESET_N   = 1'b0;
    logic        NEO_DIN   = 1'b0;
    logic [23:0] PIXEL_DATA;
    logic [1:0]  PIXEL_INDEX;
    logic        PIXEL_VALID, FRAME_END, ERROR, NEO_DOUT;

    anton_neopixel_rx #(
        .PIXELS_MAX  (PIXELS_MAX),
        .RESET_TICKS (RESET_TICKS)
    ) dut (
        .CLK_10MHZ   (CLK_10MHZ),
        .RESET_N     (RESET_N),
        .NEO_DIN     (NEO_DIN),
        .PIXEL_DATA  (PIXEL_DATA),
        .PIXEL_INDEX (PIXEL_INDEX),
        .PIXEL_VALID (PIXEL_VALID),
        .FRAME_END   (FRAME_END),
        .ERROR       (ERROR),
        .NEO_DOUT    (NEO_DOUT)
    );

    always #50 CLK_10MHZ = ~CLK_10MHZ;

    int          cyc = 0, n_fe = 0, n_err = 0, fe_cyc = 0, err_cyc = 0, val_cyc = 0;
    int          dout_hi = 0, dout_bad = 0;
    logic        din_prev = 1'b0;
    logic [25:0] got_q[$];
    bit          dout_win = 1'b0;

    always @(posedge CLK_10MHZ) begin
        #1;
        cyc++;
        if (PIXEL_VALID) begin
            got_q.push_back({PIXEL_INDEX, PIXEL_DATA});
            val_cyc = cyc;
        end
        if (FRAME_END) begin
            n_fe++;
            fe_cyc = cyc;
        end
        if (ERROR) begin
            n_err++;
            err_cyc = cyc;
        end
        if (NEO_DOUT === 1'b1) dout_hi++;
        if (dout_win && NEO_DOUT !== din_prev) dout_bad++;
        din_prev = NEO_DIN;
    end

    int          checks = 0, passed = 0, failed = 0;
    int          got_base, fe_base, err_base, hi_base, bad_base, exp_hi, last_fall_cyc;
    logic [25:0] exp_q[$];
    logic [23:0] frame_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic v);
        @(negedge CLK_10MHZ);
        NEO_DIN = v;
    endtask

    task automatic hold(input logic v, input int n);
        repeat (n) tick(v);
    endtask

    task automatic send_bit(input logic b);
        int h;
        h = b ? 8 : 3;
        hold(1'b1, h);
        tick(1'b0);
        last_fall_cyc = cyc;
        hold(1'b0, 12 - h - 1);
    endtask

    task automatic begin_test();
        got_base = got_q.size();
        fe_base  = n_fe;
        err_base = n_err;
        hi_base  = dout_hi;
        bad_base = dout_bad;
        exp_hi   = 0;
        exp_q.delete();
        frame_q.delete();
    endtask

    // Model: pixel k of a frame is reported with index k only while k < PIXELS_MAX;
    // later pixels are what a daisy-chain node forwards.
    task automatic send_frame(input bit rand_gap);
        for (int k = 0; k < frame_q.size(); k++) begin
`ifdef ANTON_NEOPIXEL_RX_PASSTHROUGH_EN
            if (k >= PIXELS_MAX) dout_win = 1'b1;
`endif
            for (int i = 0; i < 24; i++) begin
                send_bit(frame_q[k][i]);
                if (k >= PIXELS_MAX) exp_hi += frame_q[k][i] ? 8 : 3;
            end
            if (k < PIXELS_MAX) exp_q.push_back({2'(k), frame_q[k]});
            if (rand_gap) hold(1'b0, $urandom_range(0, 40));
        end
        hold(1'b0, RESET_TICKS + 10);
        dout_win = 1'b0;
    endtask

    task automatic verify(input string tag, input int exp_fe, input int exp_err);
        int n_got;
        n_got = got_q.size() - got_base;
        chk({tag, "_valid_count"}, n_got, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < n_got) chk({tag, "_pixel"}, 32'(got_q[got_base + i]), 32'(exp_q[i]));
        chk({tag, "_frame_end"}, n_fe - fe_base, exp_fe);
        chk({tag, "_error"}, n_err - err_base, exp_err);
`ifdef ANTON_NEOPIXEL_RX_PASSTHROUGH_EN
        chk({tag, "_dout_high"}, dout_hi - hi_base, exp_hi);
`else
        chk({tag, "_dout_high"}, dout_hi - hi_base, 0);
`endif
        chk({tag, "_dout_shape"}, dout_bad - bad_base, 0);
    endtask

    initial begin
        logic [23:0] v;
        int          hs, e_cyc, f_cyc;

        RESET_N = 1'b0;
        repeat (3) @(negedge CLK_10MHZ);
        chk("reset_state", {PIXEL_DATA, PIXEL_INDEX, PIXEL_VALID, FRAME_END, ERROR, NEO_DOUT}, 0);
        RESET_N = 1'b1;
        hold(1'b0, RESET_TICKS + 10);

        begin_test();
        frame_q.push_back(24'hff00d5);
        send_frame(1'b0);
        verify("single", 1, 0);
        chk("valid_latency", val_cyc - last_fall_cyc, DETECT_LAT);
        chk("frame_end_delay", fe_cyc - last_fall_cyc, EDGE_LAT + RESET_TICKS);

        begin_test();
        for (int f = 0; f < 2; f++) begin
            frame_q.delete();
            frame_q.push_back(24'hff00d5);
            frame_q.push_back(24'h008800);
            frame_q.push_back(24'h000090);
            send_frame(1'b0);
        end
        verify("three_x2", 2, 0);
        chk("three_latency", val_cyc - last_fall_cyc, DETECT_LAT);

        for (int f = 0; f < 4; f++) begin
            begin_test();
            repeat ($urandom_range(1, 5)) frame_q.push_back(24'($urandom));
            send_frame(1'b1);
            verify("random", 1, 0);
        end

        begin_test();
        v = 24'($urandom);
        for (int i = 0; i < 10; i++) send_bit(v[i]);
        hold(1'b0, RESET_TICKS + 10);
        e_cyc = err_cyc;
        f_cyc = fe_cyc;
        chk("partial_err_with_fe", e_cyc, f_cyc);
        frame_q.push_back(24'($urandom));
        send_frame(1'b0);
        verify("partial", 2, 1);

        begin_test();
        v = 24'($urandom);
        for (int i = 0; i < 10; i++) send_bit(v[i]);
        tick(1'b1);
        hs = cyc;
        hold(1'b1, 19);
        hold(1'b0, 4);
        for (int i = 11; i < 24; i++) send_bit(v[i]);
        hold(1'b0, RESET_TICKS + 10);
        chk("long_high_err_tick", err_cyc - hs, 11 + DETECT_LAT);
        frame_q.push_back(24'h008800);
        send_frame(1'b0);
        verify("long_high", 1, 1);

        begin_test();
        v = 24'($urandom);
        for (int i = 0; i < 12; i++) send_bit(v[i]);
        tick(1'b1);
        RESET_N = 1'b0;
        tick(1'b1);
        chk("reset_mid_outputs", {PIXEL_DATA, PIXEL_INDEX, PIXEL_VALID, FRAME_END, ERROR, NEO_DOUT}, 0);
        RESET_N = 1'b1;
        hold(1'b0, 9);
        for (int i = 13; i < 24; i++) send_bit(v[i]);
        for (int i = 0; i < 24; i++) send_bit(v[i]);
        hold(1'b0, RESET_TICKS + 10);
        verify("reset_mid", 0, 0);

        begin_test();
        for (int k = 0; k < 4; k++) frame_q.push_back(24'($urandom));
        send_frame(1'b0);
        verify("overflow", 1, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
